// File: rtl/block_d_sched_pkg.sv
// Shared types and helpers for the block_d round-robin front-end scheduler.
package block_d_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_BURST,
        S_DRAIN,
        S_DONE
    } state_e;

    // Ceiling log2, floored at 1 so the result can always size a vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/block_d_sched_if.sv
// Requester-side and datapath-side signals of the block_d scheduler.
interface block_d_sched_if #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned NUM_REQ    = 2
);
    import block_d_sched_pkg::*;

    localparam int unsigned ID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         dp_data_in;
    logic                          dp_clk_en;
    logic                          dp_data_en;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic                          done;

    modport master (
        output req_valid, req_data, dp_data_en,
        input  req_ready, dp_data_in, dp_clk_en, grant_id, busy, done
    );

    modport slave (
        input  req_valid, req_data, dp_data_en,
        output req_ready, dp_data_in, dp_clk_en, grant_id, busy, done
    );

endinterface

// File: rtl/block_d_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import block_d_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest hit is kept last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/block_d_sched.sv
// Shares block_d's single data_in/clk_en entry between NUM_REQ requesters,
// one burst of up to BURST_LEN beats per grant followed by SETTLE drain cycles.
module block_d_sched
    import block_d_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned SETTLE     = 2
) (
    input  logic            clk,
    input  logic            rst,
    block_d_sched_if.slave  bus
);

    localparam int unsigned ID_W        = clog2(NUM_REQ);
    localparam int unsigned CNT_W       = clog2(BURST_LEN + 1);
    localparam int unsigned SET_W       = clog2(SETTLE + 1);
    localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_e                state, next_state;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       winner;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [CNT_W-1:0]      beat_cnt;
    logic [SET_W-1:0]      drain_cnt;
    logic [DATA_WIDTH-1:0] dp_data_q;
    logic                  dp_clk_en_q;
    logic [ID_W-1:0]       grant_id_q;
    logic                  busy_q;
    logic                  done_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]       arb_idx;
    logic                  arb_any;
    logic                  win_valid_c;
    logic                  beat_c;
    logic [DATA_WIDTH-1:0] win_data_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign win_valid_c = |(bus.req_valid & win_onehot);
    assign win_data_c  = bus.req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Burst ends on the beat that fills the counter or on the first idle cycle.
    always_comb begin
        next_state = state;
        beat_c     = 1'b0;
        unique case (state)
            S_IDLE:  if (|bus.req_valid) next_state = S_GRANT;
            S_GRANT: next_state = arb_any ? S_BURST : S_IDLE;
            S_BURST: begin
                beat_c = win_valid_c;
                if (!win_valid_c || beat_cnt == CNT_W'(BURST_LEN - 1))
                    next_state = (SETTLE == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.dp_data_en || drain_cnt == SET_W'(SETTLE_LAST))
                    next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            winner      <= '0;
            win_onehot  <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            dp_data_q   <= '0;
            dp_clk_en_q <= 1'b0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (state == S_GRANT) begin
                winner     <= arb_idx;
                win_onehot <= arb_gnt;
                beat_cnt   <= '0;
                grant_id_q <= arb_idx;
            end else begin
                if (beat_c) beat_cnt <= beat_cnt + CNT_W'(1);
                if (next_state == S_IDLE) grant_id_q <= '0;
            end

            drain_cnt <= (state == S_DRAIN) ? drain_cnt + SET_W'(1) : '0;

            // Datapath sees each beat one cycle later; drain re-enables with data held.
            if (beat_c) dp_data_q <= win_data_c;
            dp_clk_en_q <= beat_c || (state == S_DRAIN);

            // Last owner drops to lowest priority for the next arbitration.
            if (state == S_DONE)
                ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

            busy_q <= (next_state == S_BURST) || (next_state == S_DRAIN);
            done_q <= (next_state == S_DONE);
        end
    end

    assign bus.req_ready  = (state == S_BURST) ? (bus.req_valid & win_onehot) : '0;
    assign bus.dp_data_in = dp_data_q;
    assign bus.dp_clk_en  = dp_clk_en_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_block_d_sched.sv
// Scoreboard bench for block_d_sched: random request streams against a burst-level model.
module tb_block_d_sched;

    logic clk;
    logic rst;

    block_d_sched_if #(.DATA_WIDTH(4), .NUM_REQ(2)) bus_a ();
    block_d_sched_if #(.DATA_WIDTH(2), .NUM_REQ(3)) bus_b ();

    block_d_sched #(.DATA_WIDTH(4), .NUM_REQ(2), .BURST_LEN(4), .SETTLE(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    block_d_sched #(.DATA_WIDTH(2), .NUM_REQ(3), .BURST_LEN(1), .SETTLE(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  nb;
        logic [3:0]  drain;
        logic [15:0] data;
    } exp_t;

    exp_t q_a[$];
    int   q_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] str_a [2][16];
    int         pos_a [2];
    int         len_a [2];
    int         ptr_m;
    bit         b_active;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic drive_a();
        for (int i = 0; i < 2; i++) begin
            bus_a.req_valid[i]      = (pos_a[i] < len_a[i]);
            bus_a.req_data[i*4 +: 4] = (pos_a[i] < 16) ? str_a[i][pos_a[i]] : 4'd0;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) str_a[i][j] = 4'($urandom);
    endtask

    // One clock: note the handshake seen this cycle, then advance the streams after the edge.
    task automatic step_a(output logic [1:0] hs);
        @(negedge clk);
        hs = bus_a.req_valid & bus_a.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (hs[i]) pos_a[i]++;
        drive_a();
    endtask

    // Reference: serve requester streams in round-robin bursts of at most 4 beats.
    task automatic run_round(input int l0, input int l1, input bit en);
        int   rem [2];
        int   off [2];
        int   w;
        int   nb;
        exp_t e;
        bit   ok;
        logic [1:0] hs;
        rem = '{l0, l1};
        off = '{0, 0};
        while (rem[0] + rem[1] > 0) begin
            w = (rem[ptr_m] > 0) ? ptr_m : 1 - ptr_m;
            nb = (rem[w] < 4) ? rem[w] : 4;
            e.id    = 4'(w);
            e.nb    = 4'(nb);
            e.drain = en ? 4'd1 : 4'd2;
            e.data  = '0;
            for (int b = 0; b < nb; b++) e.data[b*4 +: 4] = str_a[w][off[w] + b];
            q_a.push_back(e);
            rem[w] -= nb;
            off[w] += nb;
            ptr_m = (w + 1) % 2;
        end
        pos_a = '{0, 0};
        len_a = '{l0, l1};
        bus_a.dp_data_en = en;
        drive_a();
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step_a(hs);
            if (q_a.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("round_complete", 32'(ok), 32'd1);
        if (!ok) q_a.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor A: gather datapath enables per burst, judge them when done pulses.
    logic [3:0] got [16];
    int         en_cnt   = 0;
    bit         post_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic [3:0] last;
        if (!rst) begin
            en_cnt    = 0;
            post_done = 1'b0;
        end else begin
            check("a_ready_onehot0", 32'($onehot0(bus_a.req_ready)), 32'd1);
            if (post_done) begin
                check("a_idle_after_done", {bus_a.busy, bus_a.grant_id}, 32'd0);
                post_done = 1'b0;
            end
            if (bus_a.dp_clk_en && !bus_a.done) check("a_busy_in_burst", 32'(bus_a.busy), 32'd1);
            if (bus_a.dp_clk_en) begin
                if (en_cnt < 16) got[en_cnt] = bus_a.dp_data_in;
                en_cnt++;
            end
            if (bus_a.done) begin
                check("a_done_expected", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_grant_id", 32'(bus_a.grant_id), 32'(e.id));
                    check("a_busy_at_done", 32'(bus_a.busy), 32'd0);
                    check("a_enable_cycles", 32'(en_cnt), 32'(e.nb) + 32'(e.drain));
                    for (int b = 0; b < int'(e.nb) && b < en_cnt; b++)
                        check("a_beat_data", 32'(got[b]), 32'(e.data[b*4 +: 4]));
                    last = e.data[(int'(e.nb) - 1)*4 +: 4];
                    for (int b = int'(e.nb); b < en_cnt && b < 16; b++)
                        check("a_drain_hold", 32'(got[b]), 32'(last));
                end
                en_cnt    = 0;
                post_done = 1'b1;
            end
        end
    end

    // Monitor B: single-beat bursts with no drain; data of requester i is i+1.
    int         b_en = 0;
    logic [1:0] b_dat;

    always @(negedge clk) begin
        int id;
        if (!rst) begin
            b_en = 0;
        end else if (b_active) begin
            check("b_ready_onehot0", 32'($onehot0(bus_b.req_ready)), 32'd1);
            if (bus_b.dp_clk_en) begin
                b_en++;
                b_dat = bus_b.dp_data_in;
            end
            if (bus_b.done) begin
                check("b_done_expected", 32'(q_b.size() > 0), 32'd1);
                if (q_b.size() > 0) begin
                    id = q_b.pop_front();
                    check("b_grant_id", 32'(bus_b.grant_id), 32'(id));
                    check("b_en_at_done", 32'(bus_b.dp_clk_en), 32'd1);
                    check("b_one_beat", 32'(b_en), 32'd1);
                    check("b_beat_data", 32'(b_dat), 32'(id + 1));
                end
                b_en = 0;
            end
        end
    end

    initial begin
        logic [1:0] hs;
        int         nbeats;
        bit         ok;

        rst              = 1'b0;
        ptr_m            = 0;
        b_active         = 1'b0;
        pos_a            = '{0, 0};
        len_a            = '{0, 0};
        bus_a.req_valid  = 2'b11;
        bus_a.req_data   = '1;
        bus_a.dp_data_en = 1'b0;
        bus_b.req_valid  = '0;
        bus_b.req_data   = '0;
        bus_b.dp_data_en = 1'b0;

        // Held in reset with requests pending: everything stays quiet.
        #22;
        check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_clk_en", 32'(bus_a.dp_clk_en), 32'd0);
        check("rst_data_in", 32'(bus_a.dp_data_in), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_grant_id", 32'(bus_a.grant_id), 32'd0);
        bus_a.req_valid = 2'b00;
        #1 rst = 1'b1;

        // Single requester, data 1,0,1,1, full drain.
        fill_rand();
        str_a[0][0] = 4'd1; str_a[0][1] = 4'd0; str_a[0][2] = 4'd1; str_a[0][3] = 4'd1;
        run_round(4, 0, 1'b0);
        // Both continuously valid: alternating full bursts.
        fill_rand();
        run_round(8, 8, 1'b0);
        // Early end after two beats.
        fill_rand();
        run_round(0, 2, 1'b0);
        // Drain aborted by datapath status.
        fill_rand();
        run_round(3, 5, 1'b1);

        for (int r = 0; r < 20; r++) begin
            int l0, l1;
            fill_rand();
            l0 = int'($urandom_range(0, 9));
            l1 = int'($urandom_range(0, 9));
            if (l0 + l1 == 0) l0 = 1;
            run_round(l0, l1, 1'($urandom_range(0, 1)));
        end

        // Leave the pointer at 1, then reset in the middle of a burst.
        fill_rand();
        run_round(3, 0, 1'b0);
        fill_rand();
        pos_a = '{0, 0};
        len_a = '{8, 0};
        bus_a.dp_data_en = 1'b0;
        drive_a();
        nbeats = 0;
        for (int c = 0; c < 50 && nbeats < 2; c++) begin
            step_a(hs);
            nbeats += int'(hs[0]);
        end
        check("pre_rst_beats", 32'(nbeats), 32'd2);
        check("pre_rst_clk_en", 32'(bus_a.dp_clk_en), 32'd1);
        check("pre_rst_busy", 32'(bus_a.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_clk_en", 32'(bus_a.dp_clk_en), 32'd0);
        check("async_rst_busy", 32'(bus_a.busy), 32'd0);
        check("async_rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        len_a = '{0, 0};
        drive_a();
        q_a.delete();
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        fill_rand();
        run_round(2, 2, 1'b0);

        // Three requesters, one beat each, no drain.
        for (int k = 0; k < 7; k++) q_b.push_back(k % 3);
        bus_b.req_data  = {2'd3, 2'd2, 2'd1};
        b_active        = 1'b1;
        bus_b.req_valid = 3'b111;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (q_b.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_sequence_complete", 32'(ok), 32'd1);
        b_active = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
